// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute-stage datapath and muldiv_unit.
//
// Handshake: the core raises start with funct3/op_a/op_b valid; the unit
// accepts only while busy=0 and flush=0. busy stays high from the cycle after
// acceptance through the done cycle. done is a single-cycle pulse, and result
// is valid in that cycle and held until the next result is committed.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              flush;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on unsigned
// magnitudes, sign fix-up folded into the commit of the result register.
// acc holds {high, low}: for multiply {partial product, multiplier}, for
// divide {remainder, dividend/quotient}. bop holds multiplicand or divisor.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_unit_if.slave     bus,
    output logic [1:0]       state_dbg
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int AW    = 2 * DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0] bop_q, bop_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [DATA_W:0]   sum, shl, trial;

    // Pick the architectural result from the final accumulator and sign flag.
    function automatic logic [DATA_W-1:0] fix_result(input logic [2:0] f,
                                                     input logic neg,
                                                     input logic [AW-1:0] acc);
        logic [AW-1:0]     full;
        logic [DATA_W-1:0] sel;
        full = neg ? -acc : acc;
        sel  = f[1] ? acc[AW-1:DATA_W] : acc[DATA_W-1:0];
        if (!f[2])
            fix_result = (f == 3'b000) ? full[DATA_W-1:0] : full[AW-1:DATA_W];
        else
            fix_result = neg ? -sel : sel;
    endfunction

    // Operand decode for a request presented in IDLE.
    always_comb begin
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed && bus.op_a[DATA_W-1];
        b_neg    = b_signed && bus.op_b[DATA_W-1];
        a_mag    = a_neg ? -bus.op_a : bus.op_a;
        b_mag    = b_neg ? -bus.op_b : bus.op_b;
        div_zero = bus.funct3[2] && (bus.op_b == '0);
        div_ovf  = bus.funct3[2] && b_signed &&
                   (bus.op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (&bus.op_b);
    end

    // Next-state and datapath step.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        bop_d    = bop_q;
        result_d = result_q;
        sum      = {1'b0, acc_q[AW-1:DATA_W]} + (acc_q[0] ? {1'b0, bop_q} : '0);
        shl      = {acc_q[AW-1:DATA_W], acc_q[DATA_W-1]};
        trial    = shl - {1'b0, bop_q};
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d = bus.funct3;
                    if (div_zero || div_ovf) begin
                        // Preload acc so the normal selection yields the
                        // special value: low half for quotient, high for remainder.
                        neg_d    = 1'b0;
                        acc_d    = div_zero ? {bus.op_a, {DATA_W{1'b1}}}
                                            : {{DATA_W{1'b0}}, bus.op_a};
                        result_d = fix_result(bus.funct3, 1'b0, acc_d);
                        state_d  = S_DONE;
                    end else begin
                        // Remainder follows the dividend; everything else XORs.
                        neg_d   = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        acc_d   = {{DATA_W{1'b0}}, a_mag};
                        bop_d   = b_mag;
                        count_d = CNT_W'(DATA_W);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!f3_q[2])
                        acc_d = {sum, acc_q[DATA_W-1:1]};
                    else if (!trial[DATA_W])
                        acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else
                        acc_d = {shl[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        result_d = fix_result(f3_q, neg_q, acc_d);
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            bop_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            bop_q    <= bop_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign state_dbg  = state_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M funct3 set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the next-generation core.
- Sits beside the ALU in the datapath's execute stage. The datapath issues an operation with a start pulse and stalls on busy. The result is captured when done pulses.
- A flush input lets the core abort an in-flight operation on branch/jump redirect.

Parameters:
- DATA_W, 32, operand/result width in bits; legal range >= 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  issue request; sampled only in IDLE
- flush  input  1  abort in-flight operation
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  DATA_W  rs1 operand; captured on accepted start
- op_b  input  DATA_W  rs2 operand; captured on accepted start
- busy  output  1  high whenever the state is not IDLE
- done  output  1  single-cycle pulse; result valid
- result  output  DATA_W  registered result; held until the next accepted start

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, and all internal registers cleared. Reset overrides every other input, including mid-operation.
- States are IDLE, CALC and DONE.
- IDLE:
  - start=1 and flush=0 accepts the request. The unit latches funct3, the operand magnitudes and the result sign, then goes to CALC with count=DATA_W.
  - A fast-path case goes directly to DONE instead.
  - flush=1 ignores start.
- Fast path (division only), taken straight to DONE:
  - divisor==0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a = most-negative, op_b = -1) on DIV returns op_a; on REM returns 0.
- CALC:
  - Performs one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, on unsigned magnitudes.
  - Decrements count each step. When count reaches 1 at the clock edge, the next state is DONE.
  - flush=1 returns to IDLE at the next edge; no done is produced and result is unchanged.
- DONE:
  - Applies sign correction, writes result, and asserts done=1 for exactly this cycle.
  - Returns to IDLE at the next edge. flush is ignored here because the result is already committed.
- Latency, with start sampled at the end of cycle 0:
  - Normal operation: CALC occupies cycles 1..DATA_W and done is high in cycle DATA_W+1 (cycle 33 for DATA_W=32).
  - Fast path: done is high in cycle 1.
- busy is high from cycle 1 through the done cycle inclusive. start is ignored while busy=1.
- Back-to-back issue: the earliest next start is sampled in the cycle after done, i.e. the first IDLE cycle.
- Width and sign rules:
  - The product is 2*DATA_W bits. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signedness of a/b: MULH is s/s, MULHSU is s/u, MULHU is u/u.
  - Signed result = two's-complement negation of the full-width magnitude when the operand signs differ.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
- Operands are captured on accept. Changes to op_a, op_b or funct3 after acceptance have no effect.

Test Plan (DATA_W=32):
- MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, busy high in cycles 1..33.
- High-half multiplies (run back-to-back):
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - Each new start is issued in the cycle after done.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU -> 2.
- Fast path:
  - DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with done in cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush: start DIVU 1000/3, assert flush in cycle 10 -> busy=0 in cycle 11, no done pulse, result keeps the prior value. A new start in cycle 11 completes with 333.
- Reset mid-CALC (cycle 5) -> next cycle busy=0, done=0, result=0. A start of 1000/3 issued while busy (cycles 1..4) is ignored.
